// File: rtl/aes_inv_round_ctrl_if.sv
// Request/response stream bundle for the iterative AES decryption engine.
// master = requester/consumer side, slave = the engine.
interface aes_inv_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [1:0]   in_size;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, in_size, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_size, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption: one inverse round per clock on a shared datapath,
// round keys fetched one per cycle from an external key-schedule store.
module aes_inv_round_ctrl #(
   parameter  int MAX_NR = 14,
   localparam int IDX_W  = $clog2(MAX_NR + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_inv_round_ctrl_if.slave  bus,
   input  logic                 flush,
   output logic [IDX_W-1:0]     rk_idx,
   input  logic [127:0]         rk_data,
   output logic                 busy,
   output logic                 err
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] INIT  = 3'd1;
   localparam logic [2:0] ROUND = 3'd2;
   localparam logic [2:0] FINAL = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] rnd_q, rnd_d;
   logic [127:0]     st_q, st_d;
   logic [1:0]       size_q, size_d;
   logic             err_q, err_d;

   function automatic logic [IDX_W-1:0] nr_of(input logic [1:0] sz);
      case (sz)
         2'b00:   return IDX_W'(10);
         2'b01:   return IDX_W'(12);
         default: return IDX_W'(14);
      endcase
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0), after the inverse affine map.
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] a, a2, a4, a8, a16, a32, a64, a128;
      a    = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      a2   = gmul(a, a);
      a4   = gmul(a2, a2);
      a8   = gmul(a4, a4);
      a16  = gmul(a8, a8);
      a32  = gmul(a16, a16);
      a64  = gmul(a32, a32);
      a128 = gmul(a64, a64);
      return gmul(gmul(gmul(a2, a4), gmul(a8, a16)), gmul(gmul(a32, a64), a128));
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      st_d    = st_q;
      size_d  = size_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && !flush) begin
               st_d   = bus.in_data;
               size_d = bus.in_size;
               if (bus.in_size == 2'b11) begin
                  err_d = 1'b1;
               end else begin
                  rnd_d   = nr_of(bus.in_size);
                  state_d = INIT;
               end
            end
         end
         INIT: begin
            st_d    = st_q ^ rk_data;
            rnd_d   = rnd_q - IDX_W'(1);
            state_d = ROUND;
         end
         ROUND: begin
            st_d  = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data);
            rnd_d = rnd_q - IDX_W'(1);
            if (rnd_q == IDX_W'(1)) state_d = FINAL;
         end
         FINAL: begin
            st_d    = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over everything, including a DONE handshake in the same cycle.
      if (flush && state_q != IDLE) begin
         state_d = IDLE;
         rnd_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         st_q    <= '0;
         size_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         st_q    <= st_d;
         size_q  <= size_d;
         err_q   <= err_d;
      end
   end

   // Round counter doubles as key index: Nr in INIT, r in ROUND, 0 in FINAL.
   assign rk_idx        = (state_q == INIT || state_q == ROUND || state_q == FINAL) ? rnd_q : '0;
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = st_q;
   assign busy          = (state_q != IDLE);
   assign err           = err_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: forward-AES reference model, key-store model and
// an output scoreboard fed by the stimulus process.
module tb_aes_inv_round_ctrl;
   logic         clk;
   logic         rst_n;
   logic         flush;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         busy;
   logic         err;

   aes_inv_round_ctrl_if bus();

   aes_inv_round_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .flush   (flush),
      .rk_idx  (rk_idx),
      .rk_data (rk_data),
      .busy    (busy),
      .err     (err)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0]   sbox [256];
   logic [127:0] ks   [16];
   logic [127:0] exp_q[$];

   localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

   assign rk_data = ks[rk_idx];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // Forward S-box from its definition: brute-force inverse, then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk);
      logic [31:0] w[60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
         ks[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[0][127-8*i -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rd < nr) begin
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[rd][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic int nr_for(input logic [1:0] sz);
      return (sz == 2'b00) ? 10 : (sz == 2'b01) ? 12 : 14;
   endfunction

   task automatic accept(input logic [127:0] ct, input logic [1:0] sz);
      chk("in_ready_before_accept", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = ct;
      bus.in_size  = sz;
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = rnd128();
      bus.in_size  = 2'($urandom_range(0, 3));
   endtask

   // Accept, then follow the key-index sequence until out_valid rises.
   task automatic go(input logic [127:0] ct, input logic [1:0] sz);
      logic [3:0] seq[$];
      int nr, cnt, bad;
      nr  = nr_for(sz);
      cnt = 0;
      bad = 0;
      accept(ct, sz);
      while (!bus.out_valid && cnt < 40) begin
         seq.push_back(rk_idx);
         step();
         cnt++;
      end
      chk("latency_edges", cnt, nr + 1);
      foreach (seq[i]) if (int'(seq[i]) != nr - i) bad++;
      chk("rk_idx_sequence_errors", bad, 0);
   endtask

   // Full transaction with out_ready high: push expectation, run, complete handshake.
   task automatic txn(input logic [127:0] ct, input logic [1:0] sz, input logic [127:0] pt);
      exp_q.push_back(pt);
      go(ct, sz);
      step();
      chk("busy_after_handshake", busy, 0);
   endtask

   // Scoreboard monitor: pops one expectation per output handshake.
   initial begin
      logic [127:0] want;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output got=%h want=none", bus.out_data);
            end else begin
               want = exp_q.pop_front();
               chk("out_data", bus.out_data, want);
            end
         end
      end
   end

   initial begin
      logic [127:0] pt2, ct2, key;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_size   = 2'b00;
      bus.out_ready = 1'b1;
      build_sbox();
      expand(FIPS_KEY, 4);
      repeat (3) step();
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_err", err, 0);
      chk("reset_rk_idx", rk_idx, 0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_reset", bus.in_ready, 1);
      step();

      // FIPS-197 vectors for all three key sizes
      txn(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00, FIPS_PT);
      expand(FIPS_KEY, 6);
      txn(128'hdda97ca4864cdfe06eaf70a0ec0d7191, 2'b01, FIPS_PT);
      expand(FIPS_KEY, 8);
      txn(128'h8ea2b7ca516745bfeafc49904b496089, 2'b10, FIPS_PT);

      // Output back-pressure with a competing request
      expand(FIPS_KEY, 4);
      pt2 = rnd128();
      ct2 = encrypt(pt2, 10);
      exp_q.push_back(FIPS_PT);
      bus.out_ready = 1'b0;
      go(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00);
      bus.in_valid = 1'b1;
      bus.in_data  = ct2;
      bus.in_size  = 2'b00;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_out_data", bus.out_data, FIPS_PT);
         chk("stall_out_valid", bus.out_valid, 1);
         chk("stall_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("stall_release_idle", busy, 0);
      txn(ct2, 2'b00, pt2);

      // Illegal key size
      accept(rnd128(), 2'b11);
      chk("illegal_err_pulse", err, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_out_valid", bus.out_valid, 0);
      chk("illegal_in_ready", bus.in_ready, 1);
      step();
      chk("illegal_err_cleared", err, 0);
      chk("illegal_busy_after", busy, 0);

      // Asynchronous reset in the 5th ROUND cycle
      accept(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", busy, 0);
      chk("midreset_out_valid", bus.out_valid, 0);
      chk("midreset_err", err, 0);
      step();
      rst_n = 1'b1;
      step();
      txn(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00, FIPS_PT);

      // Flush in the 3rd ROUND cycle
      accept(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00);
      repeat (3) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_round_busy", busy, 0);
      chk("flush_round_out_valid", bus.out_valid, 0);
      chk("flush_round_err", err, 0);
      repeat (20) step();
      chk("flush_round_quiet", bus.out_valid, 0);

      // Flush together with out_ready in DONE: no handshake may be seen
      bus.out_ready = 1'b0;
      go(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_done_busy", busy, 0);
      chk("flush_done_out_valid", bus.out_valid, 0);

      // Random keys and plaintexts for every size
      for (int sz = 0; sz < 3; sz++) begin
         key = '0;
         key = {rnd128(), rnd128()};
         expand({key, 128'h0} >> 0, 4 + 2*sz);
         for (int n = 0; n < 3; n++) begin
            pt2 = rnd128();
            ct2 = encrypt(pt2, nr_for(2'(sz)));
            txn(ct2, 2'(sz), pt2);
         end
      end

      repeat (3) step();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
